fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Fetch-issue controller that sequences the program_counter block. It drives the PC's ld/inc/next_pc inputs and fetches the word at the current PC over an instruction-memory ready handshake. It holds the fetched instruction, offers it to decode over a valid/ready handshake, and supports execute-stage redirects, halt, and a memory-timeout fault. It sits between program_counter, instruction memory and the decode stage.

Parameters:
WIDTH, 32, PC/address width; must match program_counter WIDTH.
IW, 32, instruction word width.
TIMEOUT, 255, maximum consecutive FETCH cycles without imem_ready before fault; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
rst_n_a  in  1  reset, asynchronous, active-high.
start  in  1  begin or resume fetching (IDLE/HALTED only).
halt_req  in  1  level; stop at the next issue boundary.
pc  in  WIDTH  current PC from program_counter.
pc_ld  out  1  load strobe to program_counter.
pc_inc  out  1  increment strobe to program_counter (PC += 4).
next_pc  out  WIDTH  load value to program_counter.
imem_req  out  1  fetch request.
imem_addr  out  WIDTH  fetch address (= pc).
imem_ready  in  1  read data valid this cycle.
imem_rdata  in  IW  instruction word.
redirect_valid  in  1  branch/jump taken.
redirect_pc  in  WIDTH  redirect target.
instr  out  IW  held instruction.
instr_pc  out  WIDTH  PC of held instruction.
instr_valid  out  1  instruction offered to decode.
instr_ready  in  1  decode accepts.
busy  out  1  high in FETCH or ISSUE.
fault  out  1  sticky timeout flag.
retired_cnt  out  32  count of accepted instructions; wraps.

Behaviour:
- Reset (async, immediate): state IDLE; instr, instr_pc, retired_cnt and the wait counter all 0; every output 0.
- States: IDLE, FETCH, ISSUE, HALTED, FAULT. pc_ld, pc_inc, imem_req and instr_valid are combinational from state and inputs. All other outputs are registered.
- IDLE / HALTED: busy=0. start=1 moves to FETCH. Redirect and halt_req are ignored here.
- FETCH: imem_req=1, imem_addr=pc. Priority order for this state:
  1. redirect_valid: pc_ld=1, next_pc=redirect_pc, imem_req=0; rdata discarded; stay in FETCH; wait counter cleared.
  2. halt_req with imem_ready=0: go to HALTED; fetch aborted; PC unchanged.
  3. imem_ready: capture instr=imem_rdata and instr_pc=pc; pc_inc=1 in the same cycle; go to ISSUE. Halt is not taken on this cycle.
  4. Otherwise: wait counter +1. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with imem_ready=0, go to FAULT.
- Dropping imem_req before imem_ready is legal; the memory ignores an abandoned request.
- ISSUE: instr_valid=1; instr and instr_pc are held stable until the handshake completes.
  - redirect_valid has priority: instr_valid is forced 0 that cycle, no handshake occurs and no retire is counted; pc_ld=1, next_pc=redirect_pc; go to FETCH.
  - instr_valid && instr_ready: retired_cnt +1. Go to HALTED if halt_req=1, else to FETCH.
- FAULT: fault=1, all strobes 0. Only reset exits.
- pc_ld and pc_inc are never high together. next_pc=0 whenever pc_ld=0.
- Latency: with zero-wait memory and decode always ready, one instruction issues every 2 cycles (FETCH, ISSUE).
- PC stepping: the PC advances by 4 per fetch, via program_counter. The new PC is visible the cycle after the strobe.
- Wait counter: clog2(TIMEOUT+1) bits. Cleared on entering FETCH, on imem_ready, and on redirect.
- Reset mid-operation: abandons everything. instr_valid drops at once; retired_cnt returns to 0.

Test Plan:
- Reset, then start with imem_ready tied 1 and instr_ready tied 1, words 0xA0,0xA1,0xA2 -> instr_pc 0,4,8 issued on cycles 2,4,6; retired_cnt=3; pc_ld never 1.
- Hold instr_ready=0 for 5 cycles in ISSUE -> instr and instr_pc stable, instr_valid high throughout, PC stays at 4, retired_cnt unchanged until accept.
- redirect_valid with redirect_pc=0x100 in ISSUE with instr_ready=1 -> no retire, pc_ld=1 and next_pc=0x100 for 1 cycle, next imem_addr=0x100.
- redirect and imem_ready in the same FETCH cycle -> pc_inc=0, instr unchanged, fetch restarts at the target.
- TIMEOUT=4 with imem_ready=0 -> fault=1 after 4 FETCH cycles; start ignored; cleared only by rst_n_a.
- halt_req during ISSUE accept -> HALTED, busy=0, PC=8. start -> fetch resumes at 8.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-path bundle: PC control, instruction-memory port, redirect input and decode handshake.
// master = the sequencer; slave = program_counter/imem/decode side.
interface fetch_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int IW    = 32
);
  logic             start;
  logic             halt_req;
  logic [WIDTH-1:0] pc;
  logic             pc_ld;
  logic             pc_inc;
  logic [WIDTH-1:0] next_pc;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic [IW-1:0]    imem_rdata;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic [IW-1:0]    instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic             busy;
  logic             fault;
  logic [31:0]      retired_cnt;

  modport master (
    input  start, halt_req, pc, imem_ready, imem_rdata, redirect_valid, redirect_pc, instr_ready,
    output pc_ld, pc_inc, next_pc, imem_req, imem_addr, instr, instr_pc, instr_valid,
           busy, fault, retired_cnt
  );

  modport slave (
    output start, halt_req, pc, imem_ready, imem_rdata, redirect_valid, redirect_pc, instr_ready,
    input  pc_ld, pc_inc, next_pc, imem_req, imem_addr, instr, instr_pc, instr_valid,
           busy, fault, retired_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/issue controller: steps program_counter, fetches one word per FETCH, offers it in ISSUE.
// Two cycles per instruction at best; stalls on imem_ready and instr_ready; redirects win over both.
module fetch_sequencer #(
  parameter int WIDTH   = 32,
  parameter int IW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n_a,
  fetch_sequencer_if.master bus
);

  localparam int            CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED,
    S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]      retired_q, retired_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  logic             pc_ld;
  logic             pc_inc;
  logic [WIDTH-1:0] next_pc;
  logic             imem_req;
  logic             instr_valid;

  always_ff @(posedge clk or posedge rst_n_a) begin
    if (rst_n_a) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
      retired_q  <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retired_q  <= retired_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    retired_d   = retired_q;
    wait_d      = '0;
    pc_ld       = 1'b0;
    pc_inc      = 1'b0;
    next_pc     = '0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.redirect_valid) begin
          // Abandon the in-flight request; memory ignores a dropped imem_req.
          imem_req = 1'b0;
          pc_ld    = 1'b1;
          next_pc  = bus.redirect_pc;
        end else if (bus.halt_req && !bus.imem_ready) begin
          state_d = S_HALTED;
        end else if (bus.imem_ready) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = bus.pc;
          pc_inc     = 1'b1;
          state_d    = S_ISSUE;
        end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_ISSUE: begin
        if (bus.redirect_valid) begin
          pc_ld   = 1'b1;
          next_pc = bus.redirect_pc;
          state_d = S_FETCH;
        end else begin
          instr_valid = 1'b1;
          if (bus.instr_ready) begin
            retired_d = retired_q + 32'd1;
            state_d   = bus.halt_req ? S_HALTED : S_FETCH;
          end
        end
      end

      default: ;
    endcase

    busy_d  = (state_d == S_FETCH) || (state_d == S_ISSUE);
    fault_d = (state_d == S_FAULT);
  end

  assign bus.pc_ld       = pc_ld;
  assign bus.pc_inc      = pc_inc;
  assign bus.next_pc     = next_pc;
  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = (state_q == S_FETCH) ? bus.pc : '0;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;
  assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model (PC arithmetic, stall count, retire count).
module tb_fetch_sequencer;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] salt = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.WIDTH(32), .IW(32)) bus ();

  fetch_sequencer #(.WIDTH(32), .IW(32), .TIMEOUT(TMO)) dut (
    .clk    (clk),
    .rst_n_a(rst),
    .bus    (bus)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a, input logic [31:0] s);
    return (a >> 2) + 32'hA0 + s;
  endfunction

  // Environment: program_counter and a combinational instruction memory.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.pc <= 32'd0;
    else if (bus.pc_ld) bus.pc <= bus.next_pc;
    else if (bus.pc_inc) bus.pc <= bus.pc + 32'd4;
  end
  assign bus.imem_rdata = word_of(bus.pc, salt);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, evaluated at each falling edge on the inputs of that cycle.
  typedef enum {M_IDLE, M_FETCH, M_ISSUE, M_HALT, M_FAULT} mode_t;
  mode_t       m_mode, n_mode;
  logic [31:0] m_pc, m_instr, m_ipc, m_ret;
  int          m_stall;
  logic        e_ld, e_inc, e_req, e_vld;
  logic [31:0] e_npc, e_addr;

  always @(negedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_pc = 0; m_instr = 0; m_ipc = 0; m_ret = 0; m_stall = 0;
    end
    e_ld = 0; e_inc = 0; e_req = 0; e_vld = 0; e_npc = 0; e_addr = 0;
    n_mode = m_mode;
    if (!rst) begin
      case (m_mode)
        M_IDLE, M_HALT: if (bus.start) n_mode = M_FETCH;
        M_FETCH: begin
          e_addr = m_pc;
          e_req  = 1;
          if (bus.redirect_valid) begin
            e_req = 0; e_ld = 1; e_npc = bus.redirect_pc;
          end else if (bus.halt_req && !bus.imem_ready) n_mode = M_HALT;
          else if (bus.imem_ready) begin
            e_inc = 1; n_mode = M_ISSUE;
          end else if (m_stall + 1 == TMO) n_mode = M_FAULT;
        end
        M_ISSUE: begin
          if (bus.redirect_valid) begin
            e_ld = 1; e_npc = bus.redirect_pc; n_mode = M_FETCH;
          end else begin
            e_vld = 1;
            if (bus.instr_ready) n_mode = bus.halt_req ? M_HALT : M_FETCH;
          end
        end
        default: ;
      endcase
    end
    chk("pc_ld", bus.pc_ld, e_ld);
    chk("pc_inc", bus.pc_inc, e_inc);
    chk("next_pc", bus.next_pc, e_npc);
    chk("imem_req", bus.imem_req, e_req);
    chk("imem_addr", bus.imem_addr, e_addr);
    chk("instr_valid", bus.instr_valid, e_vld);
    chk("busy", bus.busy, (m_mode == M_FETCH) || (m_mode == M_ISSUE));
    chk("fault", bus.fault, m_mode == M_FAULT);
    chk("instr", bus.instr, m_instr);
    chk("instr_pc", bus.instr_pc, m_ipc);
    chk("retired_cnt", bus.retired_cnt, m_ret);
    chk("pc", bus.pc, m_pc);
    if (!rst) begin
      if (m_mode == M_FETCH && n_mode == M_FETCH && !e_ld) m_stall++;
      else m_stall = 0;
      if (e_ld) m_pc = e_npc;
      if (e_inc) begin
        m_instr = word_of(m_pc, salt); m_ipc = m_pc; m_pc = m_pc + 4;
      end
      if (e_vld && bus.instr_ready) m_ret = m_ret + 1;
      m_mode = n_mode;
    end
  end

  task automatic cyc(input logic s, input logic h, input logic rdy, input logic rv,
                     input logic [31:0] rpc, input logic ir);
    @(posedge clk);
    #1;
    bus.start = s; bus.halt_req = h; bus.imem_ready = rdy;
    bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.instr_ready = ir;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 0; bus.halt_req = 0; bus.imem_ready = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.instr_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.start = 0; bus.halt_req = 0; bus.imem_ready = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.instr_ready = 0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_retired", bus.retired_cnt, 0);

    // Back-to-back issue with zero-wait memory and decode.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0, 0, 1);
      if (i % 2 == 0) chk("s1_inc", bus.pc_inc, 1);
      else begin
        chk("s1_vld", bus.instr_valid, 1);
        chk("s1_instr", bus.instr, 32'hA0 + i / 2);
        chk("s1_ipc", bus.instr_pc, 4 * (i / 2));
      end
      chk("s1_ld", bus.pc_ld, 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk("s1_retired", bus.retired_cnt, 3);

    // Decode backpressure holds the offered instruction.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("s2_vld", bus.instr_valid, 1);
      chk("s2_instr", bus.instr, 32'hA0);
      chk("s2_ipc", bus.instr_pc, 0);
      chk("s2_pc", bus.pc, 4);
      chk("s2_retired", bus.retired_cnt, 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("s2_retired_after", bus.retired_cnt, 1);

    // Redirect in ISSUE, then redirect colliding with imem_ready in FETCH.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h100, 1);
    chk("s3_ld", bus.pc_ld, 1);
    chk("s3_npc", bus.next_pc, 32'h100);
    chk("s3_vld", bus.instr_valid, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("s3_addr", bus.imem_addr, 32'h100);
    chk("s3_retired", bus.retired_cnt, 0);
    cyc(0, 0, 1, 1, 32'h200, 0);
    chk("s4_inc", bus.pc_inc, 0);
    chk("s4_req", bus.imem_req, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("s4_addr", bus.imem_addr, 32'h200);
    chk("s4_instr_held", bus.instr, 32'hA0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("s4_instr", bus.instr, 32'h120);
    chk("s4_ipc", bus.instr_pc, 32'h200);

    // Memory timeout: fault after TMO stalled FETCH cycles, sticky until reset.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TMO; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("s5_nofault", bus.fault, 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("s5_fault", bus.fault, 1);
    chk("s5_busy", bus.busy, 0);
    cyc(1, 0, 1, 0, 0, 1);
    chk("s5_fault_sticky", bus.fault, 1);
    chk("s5_req", bus.imem_req, 0);
    do_reset();
    @(negedge clk);
    chk("s5_fault_cleared", bus.fault, 0);

    // Halt at an issue boundary, then resume.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 1);
    chk("s6_busy", bus.busy, 0);
    chk("s6_pc", bus.pc, 8);
    chk("s6_retired", bus.retired_cnt, 2);
    chk("s6_req", bus.imem_req, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("s6_addr", bus.imem_addr, 8);
    cyc(0, 0, 0, 0, 0, 1);
    chk("s6_ipc", bus.instr_pc, 8);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 149) == 0);
      if (rst) salt = $urandom_range(0, 255);
      bus.start          = ($urandom_range(0, 3) == 0);
      bus.halt_req       = ($urandom_range(0, 7) == 0);
      bus.imem_ready     = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      bus.redirect_pc    = {16'd0, 16'($urandom) & 16'hFFFC};
      bus.instr_ready    = ($urandom_range(0, 9) < 7);
      @(negedge clk);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
